// File: rtl/alu_seq_muldiv.sv
// Registered ALU with single-cycle logic/arith ops, iterative shift-add multiply and restoring divide.
// Optional ALU_CARRY_OVF_EN adds SC_OUT/OVF flags and widens the multiply accumulator to 2*WIDTH.
module alu_seq_muldiv #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [3:0]       OP,
    input  logic [WIDTH-1:0] INPUTA,
    input  logic [WIDTH-1:0] INPUTB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] OUT,
    output logic             ZERO,
`ifdef ALU_CARRY_OVF_EN
    output logic             SC_OUT,
    output logic             OVF,
`endif
    output logic             DIV0
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
`ifdef ALU_CARRY_OVF_EN
    localparam int AW = 2 * WIDTH;
`else
    localparam int AW = WIDTH;
`endif
    localparam logic [WIDTH-1:0] W_LIM = WIDTH'(WIDTH);
    localparam logic [3:0] OP_MUL = 4'd7;
    localparam logic [3:0] OP_DIV = 4'd8;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q, state_d;
    logic              is_div_q, is_div_d;
    logic [AW-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]  mplier_q, mplier_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              zero_q, zero_d;
    logic              div0_q, div0_d;
    logic [WIDTH-1:0]  alu_res;
    logic [WIDTH:0]    rem_shift;
    logic              rem_ge;
`ifdef ALU_CARRY_OVF_EN
    logic              sc_q, sc_d, ovf_q, ovf_d, alu_sc, alu_ovf;
    logic [WIDTH:0]    add_w, sub_w;
    logic [2*WIDTH-1:0] lsh_wide, rsh_wide;

    assign add_w    = {1'b0, INPUTA} + {1'b0, INPUTB};
    assign sub_w    = {1'b0, INPUTA} - {1'b0, INPUTB};
    assign lsh_wide = {{WIDTH{1'b0}}, INPUTA} << INPUTB;
    assign rsh_wide = {INPUTA, {WIDTH{1'b0}}} >> INPUTB;
`endif

    // Restoring divide step: next dividend bit enters from the MSB of the shifted dividend.
    assign rem_shift = {rem_q[WIDTH-1:0], mcand_q[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, mplier_q};

    always_comb begin
        alu_res = '0;
`ifdef ALU_CARRY_OVF_EN
        alu_sc  = 1'b0;
        alu_ovf = 1'b0;
`endif
        case (OP)
            4'd0: alu_res = INPUTA + INPUTB;
            4'd1: alu_res = INPUTA - INPUTB;
            4'd2: alu_res = INPUTA & INPUTB;
            4'd3: alu_res = INPUTA | INPUTB;
            4'd4: alu_res = INPUTA ^ INPUTB;
            4'd5: alu_res = (INPUTB >= W_LIM) ? '0 : INPUTA << INPUTB;
            4'd6: alu_res = (INPUTB >= W_LIM) ? '0 : INPUTA >> INPUTB;
            OP_DIV: alu_res = '1;
            4'd9: alu_res = INPUTA;
            4'd10: alu_res = INPUTB;
            default: alu_res = '0;
        endcase
`ifdef ALU_CARRY_OVF_EN
        case (OP)
            4'd0: begin
                alu_sc  = add_w[WIDTH];
                alu_ovf = (INPUTA[WIDTH-1] == INPUTB[WIDTH-1]) && (add_w[WIDTH-1] != INPUTA[WIDTH-1]);
            end
            4'd1: begin
                alu_sc  = sub_w[WIDTH];
                alu_ovf = (INPUTA[WIDTH-1] != INPUTB[WIDTH-1]) && (sub_w[WIDTH-1] != INPUTA[WIDTH-1]);
            end
            4'd5: alu_sc = lsh_wide[WIDTH];
            4'd6: alu_sc = rsh_wide[WIDTH-1];
            default: ;
        endcase
`endif
    end

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        zero_d   = zero_q;
        div0_d   = div0_q;
`ifdef ALU_CARRY_OVF_EN
        sc_d     = sc_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (IN_VALID) begin
                    div0_d = 1'b0;
`ifdef ALU_CARRY_OVF_EN
                    sc_d  = 1'b0;
                    ovf_d = 1'b0;
`endif
                    if (OP == OP_MUL || (OP == OP_DIV && INPUTB != '0)) begin
                        is_div_d = (OP == OP_DIV);
                        mcand_d  = AW'(INPUTA);
                        mplier_d = INPUTB;
                        acc_d    = '0;
                        rem_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = BUSY;
                    end else begin
                        out_d   = alu_res;
                        zero_d  = (alu_res == '0);
                        div0_d  = (OP == OP_DIV);
                        state_d = DONE;
`ifdef ALU_CARRY_OVF_EN
                        sc_d  = alu_sc;
                        ovf_d = alu_ovf;
`endif
                    end
                end
            end
            BUSY: begin
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q - CNT_W'(1);
                if (is_div_q) begin
                    rem_d = rem_ge ? (rem_shift - {1'b0, mplier_q}) : rem_shift;
                    acc_d = {acc_q[AW-2:0], rem_ge};
                end else begin
                    mplier_d = mplier_q >> 1;
                    acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                end
                // Last iteration lands its bit and writes the result in the same cycle.
                if (cnt_q == CNT_W'(1)) begin
                    out_d   = acc_d[WIDTH-1:0];
                    zero_d  = (acc_d[WIDTH-1:0] == '0);
                    state_d = DONE;
`ifdef ALU_CARRY_OVF_EN
                    sc_d = !is_div_q && (acc_d[AW-1:WIDTH] != '0);
`endif
                end
            end
            DONE: begin
                if (OUT_READY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q  <= IDLE;
            is_div_q <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            zero_q   <= 1'b0;
            div0_q   <= 1'b0;
`ifdef ALU_CARRY_OVF_EN
            sc_q     <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            zero_q   <= zero_d;
            div0_q   <= div0_d;
`ifdef ALU_CARRY_OVF_EN
            sc_q     <= sc_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign IN_READY  = (state_q == IDLE);
    assign OUT_VALID = (state_q == DONE);
    assign OUT       = out_q;
    assign ZERO      = zero_q;
    assign DIV0      = div0_q;
`ifdef ALU_CARRY_OVF_EN
    assign SC_OUT    = sc_q;
    assign OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_muldiv.sv
// Directed, table-driven bench for alu_seq_muldiv (WIDTH=8), plus multi-cycle corner sequences.
module tb_alu_seq_muldiv;
    logic       CLK = 1'b0;
    logic       Reset, IN_VALID, OUT_READY;
    logic       IN_READY, OUT_VALID, ZERO, DIV0;
    logic [3:0] OP;
    logic [7:0] INPUTA, INPUTB, OUT;
`ifdef ALU_CARRY_OVF_EN
    logic       SC_OUT, OVF;
`endif

    int n_checks = 0;
    int n_fail = 0;

    alu_seq_muldiv #(.WIDTH(8)) dut (
        .CLK(CLK), .Reset(Reset),
        .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OP(OP), .INPUTA(INPUTA), .INPUTB(INPUTB),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUT(OUT), .ZERO(ZERO),
`ifdef ALU_CARRY_OVF_EN
        .SC_OUT(SC_OUT), .OVF(OVF),
`endif
        .DIV0(DIV0)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] out;
        logic       zero;
        logic       div0;
        int         lat;
        logic       sc;
        logic       ovf;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b, output int lat);
        @(negedge CLK);
        OP = op; INPUTA = a; INPUTB = b; IN_VALID = 1'b1;
        check("in_ready_idle", IN_READY, 1);
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        lat = 1;
        while (!OUT_VALID && lat < 40) begin
            @(posedge CLK);
            #1 lat++;
        end
    endtask

    task automatic take_result();
        @(negedge CLK);
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1 OUT_READY = 1'b0;
        check("idle_after_take", {OUT_VALID, IN_READY}, 2'b01);
    endtask

    initial begin
        int lat;
        int n_acc, n_res;
        string nm;

        vecs[0]  = '{4'd0,  8'hF0, 8'h20, 8'h10, 1'b0, 1'b0, 1, 1'b1, 1'b0};
        vecs[1]  = '{4'd1,  8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        vecs[2]  = '{4'd2,  8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[3]  = '{4'd3,  8'hF0, 8'h0C, 8'hFC, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[4]  = '{4'd4,  8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[5]  = '{4'd5,  8'h03, 8'h02, 8'h0C, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[6]  = '{4'd5,  8'h01, 8'h08, 8'h00, 1'b1, 1'b0, 1, 1'b1, 1'b0};
        vecs[7]  = '{4'd6,  8'h80, 8'h07, 8'h01, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[8]  = '{4'd6,  8'hFF, 8'd200, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        vecs[9]  = '{4'd7,  8'd13, 8'd11, 8'h8F, 1'b0, 1'b0, 9, 1'b0, 1'b0};
        vecs[10] = '{4'd7,  8'hFF, 8'hFF, 8'h01, 1'b0, 1'b0, 9, 1'b1, 1'b0};
        vecs[11] = '{4'd8,  8'd200, 8'd7, 8'd28, 1'b0, 1'b0, 9, 1'b0, 1'b0};
        vecs[12] = '{4'd8,  8'd5,  8'd0,  8'hFF, 1'b0, 1'b1, 1, 1'b0, 1'b0};
        vecs[13] = '{4'd0,  8'd1,  8'd1,  8'd2,  1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[14] = '{4'd9,  8'h5A, 8'h3C, 8'h5A, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[15] = '{4'd10, 8'h5A, 8'h3C, 8'h3C, 1'b0, 1'b0, 1, 1'b0, 1'b0};
        vecs[16] = '{4'd12, 8'h5A, 8'h3C, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0};
        vecs[17] = '{4'd8,  8'd7,  8'd200, 8'h00, 1'b1, 1'b0, 9, 1'b0, 1'b0};
        vecs[18] = '{4'd8,  8'hFF, 8'd1,  8'hFF, 1'b0, 1'b0, 9, 1'b0, 1'b0};
        vecs[19] = '{4'd1,  8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1, 1'b1, 1'b0};
        vecs[20] = '{4'd7,  8'h00, 8'h77, 8'h00, 1'b1, 1'b0, 9, 1'b0, 1'b0};
        vecs[21] = '{4'd0,  8'h7F, 8'h01, 8'h80, 1'b0, 1'b0, 1, 1'b0, 1'b1};

        Reset = 1'b1; IN_VALID = 1'b0; OUT_READY = 1'b0;
        OP = '0; INPUTA = '0; INPUTB = '0;
        repeat (2) @(posedge CLK);
        @(negedge CLK) Reset = 1'b0;
        @(negedge CLK);
        check("reset_out", OUT, 8'h00);
        check("reset_flags", {OUT_VALID, IN_READY, ZERO, DIV0}, 4'b0100);

        for (int i = 0; i < NV; i++) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            nm = $sformatf("v%0d", i);
            check({nm, "_lat"}, lat, vecs[i].lat);
            check({nm, "_out"}, OUT, vecs[i].out);
            check({nm, "_zero"}, ZERO, vecs[i].zero);
            check({nm, "_div0"}, DIV0, vecs[i].div0);
`ifdef ALU_CARRY_OVF_EN
            check({nm, "_sc"}, SC_OUT, vecs[i].sc);
            check({nm, "_ovf"}, OVF, vecs[i].ovf);
`endif
            take_result();
        end

        // Result held while the consumer stalls
        run_op(4'd7, 8'd13, 8'd11, lat);
        check("mul_hold_lat", lat, 9);
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check("mul_hold_out", OUT, 8'h8F);
            check("mul_hold_hs", {OUT_VALID, IN_READY}, 2'b10);
        end
        take_result();

        // Reset in the 4th BUSY cycle of a MUL aborts it
        @(negedge CLK);
        OP = 4'd7; INPUTA = 8'd13; INPUTB = 8'd11; IN_VALID = 1'b1;
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("busy_before_reset", IN_READY, 0);
        Reset = 1'b1;
        @(posedge CLK);
        #1;
        check("abort_state", {OUT_VALID, IN_READY}, 2'b01);
        check("abort_out", OUT, 8'h00);
        @(negedge CLK) Reset = 1'b0;
        repeat (12) begin
            @(negedge CLK);
            check("abort_no_result", OUT_VALID, 0);
        end
        run_op(4'd5, 8'h01, 8'd9, lat);
        check("lsh9_lat", lat, 1);
        check("lsh9_out", OUT, 8'h00);
        check("lsh9_zero", ZERO, 1);
        take_result();

        // Back-to-back stream with the consumer always ready
        n_acc = 0; n_res = 0;
        OUT_READY = 1'b1; OP = 4'd0; INPUTB = 8'd1;
        for (int c = 0; c < 16; c++) begin
            @(negedge CLK);
            if (OUT_VALID) begin
                check("stream_out", OUT, 8'(n_res * 3 + 8'h11));
                n_res++;
            end
            if (n_acc < 6) begin
                IN_VALID = 1'b1;
                INPUTA = 8'(n_acc * 3 + 8'h10);
                check("stream_ready", IN_READY, (c % 2 == 0) ? 1 : 0);
                if (IN_READY) n_acc++;
            end else begin
                IN_VALID = 1'b0;
            end
        end
        check("stream_count", n_res, 6);
        OUT_READY = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
